// File: rtl/pe_dot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pe_dot_sequencer
//  Description : Feeds a stream of operand pairs to an external MAC PE,
//                waits out the PE result pipeline and presents the
//                dot-product on a valid/ready output port.
//  Revision    : 1.0  initial release
// ============================================================================
module pe_dot_sequencer #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    vec_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  a_in,
  input  logic [INPUT_WIDTH-1:0]  b_in,
  output logic                    pe_clr,
  output logic                    pe_en,
  output logic [INPUT_WIDTH-1:0]  pe_a,
  output logic [INPUT_WIDTH-1:0]  pe_b,
  input  logic [OUTPUT_WIDTH-1:0] pe_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic                    drain_q, drain_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [LEN_WIDTH-1:0]    cnt_inc;
  logic                    xfer;

  // Handshake and PE drive are decoded straight from state so they are all
  // zero while reset holds the FSM in IDLE.
  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_RUN);
  assign xfer      = in_ready && in_valid;
  assign pe_clr    = (state_q == S_CLEAR);
  assign pe_en     = xfer;
  assign pe_a      = xfer ? a_in : '0;
  assign pe_b      = xfer ? b_in : '0;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign cnt_inc   = cnt_q + LEN_WIDTH'(1);

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      drain_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      drain_q    <= drain_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state logic; every register holds unless a state says otherwise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    drain_d    = drain_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (vec_len != '0) begin
            len_d   = vec_len;
            state_d = S_CLEAR;
          end else begin
            // Empty vector: nothing to accumulate, answer is zero.
            out_data_d = '0;
            state_d    = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (xfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            drain_d = 1'b0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Two cycles cover the PE's two-cycle accumulate-to-result latency.
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          drain_d    = 1'b0;
          out_data_d = pe_result;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_dot_sequencer
//  Description : Randomised and directed bench for pe_dot_sequencer with a
//                behavioural MAC PE and a sum-of-products reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  vec_len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_in, b_in;
  logic        pe_clr, pe_en;
  logic [7:0]  pe_a, pe_b;
  logic [31:0] pe_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int clr_cnt = 0, en_cnt = 0, viol = 0;

  logic [7:0] ja [256];
  logic [7:0] jb [256];

  pe_dot_sequencer #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .pe_clr(pe_clr), .pe_en(pe_en), .pe_a(pe_a), .pe_b(pe_b),
    .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural PE: accumulator updates at the end of the enable cycle,
  // result register shows it one cycle later. Deliberately not reset, so
  // an abandoned job leaves a stale sum behind.
  logic signed [31:0] acc = '0;
  logic        [31:0] res_q = '0;
  always @(posedge clk) begin
    if (pe_clr)     acc <= '0;
    else if (pe_en) acc <= acc + signed'(pe_a) * signed'(pe_b);
    res_q <= acc;
  end
  assign pe_result = res_q;

  // Per-cycle protocol observation of the PE-side interface.
  always @(negedge clk) begin
    if (!rst) begin
      if (pe_clr) clr_cnt++;
      if (pe_en)  en_cnt++;
      if (pe_clr && pe_en) viol++;
      if (!pe_en && (pe_a != 8'd0 || pe_b != 8'd0)) viol++;
      if (pe_en && (pe_a !== a_in || pe_b !== b_in)) viol++;
      if (pe_en !== (in_valid && in_ready)) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete job; entered and left at posedge+1 with the DUT idle.
  task automatic run_job(input string tag, input int len, input int gap,
                         input int hold, input bit poke);
    int c0, e0, v0, tlast, k, g;
    logic [31:0] exp;
    exp = '0;
    for (int i = 0; i < len; i++)
      exp = exp + 32'(int'(signed'(ja[i])) * int'(signed'(jb[i])));
    c0 = clr_cnt; e0 = en_cnt; v0 = viol;

    start = 1'b1; vec_len = 8'(len);
    @(negedge clk);
    tlast = cyc;
    tick;
    start = 1'b0;

    for (int i = 0; i < len; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      in_valid = 1'b0; a_in = '0; b_in = '0;
      for (int j = 0; j < g; j++) tick;
      in_valid = 1'b1; a_in = ja[i]; b_in = jb[i];
      if (poke && i == 1) begin start = 1'b1; vec_len = 8'd7; end
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin tick; @(negedge clk); k++; end
      if (k >= 20) chk({tag, "_xfer_timeout"}, 32'(in_ready), 32'd1);
      tlast = cyc;
      tick;
      start = 1'b0;
    end
    in_valid = 1'b0; a_in = '0; b_in = '0;

    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin tick; @(negedge clk); k++; end
    chk({tag, "_latency"}, 32'(cyc - tlast), (len == 0) ? 32'd1 : 32'd3);
    chk({tag, "_data"}, out_data, exp);

    for (int h = 0; h < hold; h++) begin
      tick;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_data"}, out_data, exp);
    end

    // Handshake cycle with a competing start that must be ignored.
    tick;
    out_ready = 1'b1; start = 1'b1; vec_len = 8'd5;
    @(negedge clk);
    chk({tag, "_hs_valid"}, 32'(out_valid), 32'd1);
    tick;
    out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);

    chk({tag, "_clr_cycles"}, 32'(clr_cnt - c0), (len == 0) ? 32'd0 : 32'd1);
    chk({tag, "_en_cycles"}, 32'(en_cnt - e0), 32'(len));
    chk({tag, "_protocol"}, 32'(viol - v0), 32'd0);
    tick;
  endtask

  initial begin
    int len;
    rst = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0;
    a_in = '0; b_in = '0; out_ready = 1'b0;
    tick;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_pe_ctl", {30'd0, pe_clr, pe_en}, 32'd0);
    tick;
    rst = 1'b0;
    tick;

    // Simple positive vector.
    for (int i = 0; i < 4; i++) begin ja[i] = 8'(i + 1); jb[i] = 8'd2; end
    run_job("basic", 4, 0, 0, 1'b0);

    // Signed operands.
    ja[0] = 8'hFF; jb[0] = 8'h03; ja[1] = 8'h80; jb[1] = 8'h80;
    run_job("signed", 2, 0, 0, 1'b0);

    // Empty vector.
    run_job("zero_len", 0, 0, 0, 1'b0);

    // Stalls between pairs and back-pressure on the result.
    for (int i = 0; i < 3; i++) begin ja[i] = 8'($urandom); jb[i] = 8'($urandom); end
    run_job("gaps", 3, 2, 5, 1'b0);

    // Start pulsed while busy.
    for (int i = 0; i < 4; i++) begin ja[i] = 8'($urandom); jb[i] = 8'($urandom); end
    run_job("poke", 4, 1, 0, 1'b1);

    // Reset in the middle of a run.
    start = 1'b1; vec_len = 8'd4;
    tick;
    start = 1'b0;
    tick;
    in_valid = 1'b1; a_in = 8'd9; b_in = 8'd7;
    tick;
    @(negedge clk);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    tick;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pe_en", 32'(pe_en), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    tick;
    rst = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    tick;
    ja[0] = 8'd5; jb[0] = 8'd5;
    run_job("after_rst", 1, 0, 0, 1'b0);

    // Randomised jobs.
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) begin ja[i] = 8'($urandom); jb[i] = 8'($urandom); end
      run_job($sformatf("rand%0d", r), len, -1, int'($urandom_range(0, 3)), r[0]);
    end

    // Longest vector the length field allows.
    for (int i = 0; i < 255; i++) begin ja[i] = 8'($urandom); jb[i] = 8'($urandom); end
    run_job("max_len", 255, 0, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global guard against a hung handshake.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
